// File: rtl/wb_write_ctrl_pkg.sv
// rtl/wb_write_ctrl_pkg.sv - shared widths, constants and queue entry type for wb_write_ctrl
package wb_write_ctrl_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;

  localparam logic [WB_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic WE_ON  = 1'b1;
  localparam logic WE_OFF = 1'b0;
  localparam logic RE_ON  = 1'b1;
  localparam logic RE_OFF = 1'b0;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_ctrl_queue.sv
// rtl/wb_write_ctrl_queue.sv - circular write-back queue with per-entry valid and squash-by-address
module wb_write_ctrl_queue
  import wb_write_ctrl_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_waddr,
  input  logic [DATA_W-1:0] i_push_wdata,
  input  logic              i_pop,
  input  logic              i_squash,
  input  logic [ADDR_W-1:0] i_squash_waddr,
  output logic              o_head_valid,
  output logic [ADDR_W-1:0] o_head_waddr,
  output logic [DATA_W-1:0] o_head_wdata,
  output logic [CNT_W-1:0]  o_count,
  output logic [DEPTH-1:0]  o_valid,
  output logic [ADDR_W-1:0] o_waddr [DEPTH]
);

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_waddr [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];

  // Unoccupied slots always hold valid=0, so the valid vector alone answers "owed" queries.
  // Push is last so a same-cycle younger entry survives a squash of its own address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash && (r_waddr[i] == i_squash_waddr)) begin
          r_valid[i] <= WE_OFF;
        end
      end
      if (i_pop) begin
        r_valid[r_head] <= WE_OFF;
        r_head          <= r_head + PTR_W'(1);
      end
      if (i_push) begin
        r_valid[r_tail] <= WE_ON;
        r_waddr[r_tail] <= i_push_waddr;
        r_wdata[r_tail] <= i_push_wdata;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_valid = r_valid[r_head];
  assign o_head_waddr = r_waddr[r_head];
  assign o_head_wdata = r_wdata[r_head];
  assign o_count      = r_count;
  assign o_valid      = r_valid;
  assign o_waddr      = r_waddr;

endmodule

// File: rtl/wb_write_ctrl.sv
// rtl/wb_write_ctrl.sv - regfile write-port arbiter: pipeline write-back over queued long-latency results
module wb_write_ctrl
  import wb_write_ctrl_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pipe_we,
  input  logic [ADDR_W-1:0] i_pipe_waddr,
  input  logic [DATA_W-1:0] i_pipe_wdata,
  input  logic              i_lu_valid,
  output logic              o_lu_ready,
  input  logic [ADDR_W-1:0] i_lu_waddr,
  input  logic [DATA_W-1:0] i_lu_wdata,
  input  logic [ADDR_W-1:0] i_qaddr1,
  input  logic [ADDR_W-1:0] i_qaddr2,
  output logic              o_qpend1,
  output logic              o_qpend2,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [CNT_W-1:0]  o_q_count,
  output logic              o_idle
);

  logic              w_pipe_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  logic [ADDR_W-1:0] w_head_waddr;
  logic [DATA_W-1:0] w_head_wdata;
  logic [CNT_W-1:0]  w_count;
  logic [DEPTH-1:0]  w_valid;
  logic [ADDR_W-1:0] w_waddr [DEPTH];

  assign w_pipe_wr  = !rst && i_pipe_we && (i_pipe_waddr != '0);
  assign o_lu_ready = !rst && (w_count < CNT_W'(DEPTH));
  assign w_push     = i_lu_valid && o_lu_ready && (i_lu_waddr != '0);
  assign o_q_count  = rst ? '0 : w_count;
  assign o_idle     = (o_q_count == '0);

  wb_write_ctrl_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_push),
    .i_push_waddr   (i_lu_waddr),
    .i_push_wdata   (i_lu_wdata),
    .i_pop          (w_pop),
    .i_squash       (w_pipe_wr),
    .i_squash_waddr (i_pipe_waddr),
    .o_head_valid   (w_head_valid),
    .o_head_waddr   (w_head_waddr),
    .o_head_wdata   (w_head_wdata),
    .o_count        (w_count),
    .o_valid        (w_valid),
    .o_waddr        (w_waddr)
  );

  // A squashed head is discarded even when the pipeline owns the port.
  always_comb begin
    o_rf_we    = WE_OFF;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    w_pop      = 1'b0;
    if (!rst) begin
      if (w_pipe_wr) begin
        o_rf_we    = WE_ON;
        o_rf_waddr = i_pipe_waddr;
        o_rf_wdata = i_pipe_wdata;
      end else if (w_head_valid) begin
        o_rf_we    = WE_ON;
        o_rf_waddr = w_head_waddr;
        o_rf_wdata = w_head_wdata;
      end
      w_pop = (w_count != '0) && (!w_head_valid || !w_pipe_wr);
    end
  end

  always_comb begin
    o_qpend1 = 1'b0;
    o_qpend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_waddr[i] == i_qaddr1)) o_qpend1 = 1'b1;
      if (w_valid[i] && (w_waddr[i] == i_qaddr2)) o_qpend2 = 1'b1;
    end
    if (rst || (i_qaddr1 == '0)) o_qpend1 = 1'b0;
    if (rst || (i_qaddr2 == '0)) o_qpend2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_ctrl.sv
// tb/tb_wb_write_ctrl.sv - directed table plus randomized reference-model bench for wb_write_ctrl
module tb_wb_write_ctrl;
  import wb_write_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [4:0]  qaddr1;
  logic [4:0]  qaddr2;
  logic        qpend1;
  logic        qpend2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  q_count;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_write_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pipe_we    (pipe_we),
    .i_pipe_waddr (pipe_waddr),
    .i_pipe_wdata (pipe_wdata),
    .i_lu_valid   (lu_valid),
    .o_lu_ready   (lu_ready),
    .i_lu_waddr   (lu_waddr),
    .i_lu_wdata   (lu_wdata),
    .i_qaddr1     (qaddr1),
    .i_qaddr2     (qaddr2),
    .o_qpend1     (qpend1),
    .o_qpend2     (qpend2),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_q_count    (q_count),
    .o_idle       (idle)
  );

  typedef struct {
    logic        rst;
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        erdy;
    logic        ep1;
    logic        ep2;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: an ordered list of pending results, oldest first.
  wb_entry_t mq[$];

  function automatic vec_t mk(input logic r, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                              input logic erdy, input logic ep1, input logic ep2, input logic [2:0] ecnt);
    vec_t v;
    v.rst = r; v.pwe = pwe; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
    v.q1 = q1; v.q2 = q2; v.ewe = ewe; v.ea = ea; v.ed = ed;
    v.erdy = erdy; v.ep1 = ep1; v.ep2 = ep2; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; pipe_we = v.pwe; pipe_waddr = v.pa; pipe_wdata = v.pd;
    lu_valid = v.lv; lu_waddr = v.la; lu_wdata = v.ld; qaddr1 = v.q1; qaddr2 = v.q2;
  endtask

  function automatic logic model_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].valid && mq[i].waddr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check(input int cyc);
    logic        pwr;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    int          n;
    n   = mq.size();
    pwr = pipe_we && pipe_waddr != 5'd0;
    ewe = 1'b0; ea = 5'd0; ed = ZERO_WORD;
    if (!rst) begin
      if (pwr) begin
        ewe = 1'b1; ea = pipe_waddr; ed = pipe_wdata;
      end else if (n > 0 && mq[0].valid) begin
        ewe = 1'b1; ea = mq[0].waddr; ed = mq[0].wdata;
      end
    end
    chk($sformatf("rnd%0d rf_we", cyc), 64'(rf_we), 64'(ewe));
    if (ewe || rst) begin
      chk($sformatf("rnd%0d rf_waddr", cyc), 64'(rf_waddr), 64'(ea));
      chk($sformatf("rnd%0d rf_wdata", cyc), 64'(rf_wdata), 64'(ed));
    end
    chk($sformatf("rnd%0d lu_ready", cyc), 64'(lu_ready), 64'(!rst && n < DEPTH));
    chk($sformatf("rnd%0d qpend1", cyc), 64'(qpend1), 64'(!rst && model_pend(qaddr1)));
    chk($sformatf("rnd%0d qpend2", cyc), 64'(qpend2), 64'(!rst && model_pend(qaddr2)));
    chk($sformatf("rnd%0d q_count", cyc), 64'(q_count), rst ? 64'd0 : 64'(n));
    chk($sformatf("rnd%0d idle", cyc), 64'(idle), 64'(rst || n == 0));
  endtask

  task automatic model_update();
    logic      pwr;
    logic      rdy;
    wb_entry_t e;
    if (rst) begin
      mq.delete();
      return;
    end
    pwr = pipe_we && pipe_waddr != 5'd0;
    rdy = mq.size() < DEPTH;
    if (mq.size() > 0 && (!mq[0].valid || !pwr)) void'(mq.pop_front());
    if (pwr) foreach (mq[i]) if (mq[i].waddr == pipe_waddr) mq[i].valid = 1'b0;
    if (lu_valid && rdy && lu_waddr != 5'd0) begin
      e.valid = 1'b1; e.waddr = lu_waddr; e.wdata = lu_wdata;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    //                  rst pwe pa     pd            lv la     ld     q1     q2     ewe ea     ed            rdy p1 p2 cnt
    tbl.push_back(mk(1, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,  5'd5,  5'd0,  0, 5'd0,  32'h0,        0, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,  5'd0,  5'd0,  1, 5'd5,  32'hDEADBEEF, 1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd0,  32'h123,      0, 5'd0,  32'h0,  5'd0,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h11, 5'd7,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd7,  5'd0,  1, 5'd7,  32'h11,       1, 1, 0, 3'd1));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd7,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd20, 32'h100,      1, 5'd1,  32'hA,  5'd1,  5'd2,  1, 5'd20, 32'h100,      1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd21, 32'h101,      1, 5'd2,  32'hB,  5'd1,  5'd2,  1, 5'd21, 32'h101,      1, 1, 0, 3'd1));
    tbl.push_back(mk(0, 1, 5'd22, 32'h102,      1, 5'd3,  32'hC,  5'd3,  5'd4,  1, 5'd22, 32'h102,      1, 0, 0, 3'd2));
    tbl.push_back(mk(0, 1, 5'd23, 32'h103,      1, 5'd4,  32'hD,  5'd1,  5'd2,  1, 5'd23, 32'h103,      1, 1, 1, 3'd3));
    tbl.push_back(mk(0, 1, 5'd24, 32'h104,      1, 5'd5,  32'hE,  5'd3,  5'd4,  1, 5'd24, 32'h104,      0, 1, 1, 3'd4));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd5,  32'hE,  5'd1,  5'd4,  1, 5'd1,  32'hA,        0, 1, 1, 3'd4));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd1,  5'd2,  1, 5'd2,  32'hB,        1, 0, 1, 3'd3));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd3,  5'd4,  1, 5'd3,  32'hC,        1, 1, 1, 3'd2));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd4,  5'd1,  1, 5'd4,  32'hD,        1, 1, 0, 3'd1));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd4,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  32'h55, 5'd9,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       0, 5'd0,  32'h0,  5'd9,  5'd0,  1, 5'd9,  32'h99,       1, 1, 0, 3'd1));
    tbl.push_back(mk(0, 1, 5'd10, 32'h77,       0, 5'd0,  32'h0,  5'd9,  5'd0,  1, 5'd10, 32'h77,       1, 0, 0, 3'd1));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd9,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd6,  32'h1,        1, 5'd6,  32'h2,  5'd6,  5'd0,  1, 5'd6,  32'h1,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd11, 32'h3,        0, 5'd0,  32'h0,  5'd6,  5'd0,  1, 5'd11, 32'h3,        1, 1, 0, 3'd1));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd6,  5'd0,  1, 5'd6,  32'h2,        1, 1, 0, 3'd1));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd6,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd12, 32'h5,        1, 5'd13, 32'h31, 5'd0,  5'd0,  1, 5'd12, 32'h5,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 5'd12, 32'h6,        1, 5'd14, 32'h32, 5'd0,  5'd0,  1, 5'd12, 32'h6,        1, 0, 0, 3'd1));
    tbl.push_back(mk(0, 1, 5'd12, 32'h7,        1, 5'd15, 32'h33, 5'd13, 5'd15, 1, 5'd12, 32'h7,        1, 1, 0, 3'd2));
    tbl.push_back(mk(1, 1, 5'd12, 32'h8,        0, 5'd0,  32'h0,  5'd13, 5'd14, 0, 5'd0,  32'h0,        0, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd13, 5'd15, 0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd14, 5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0,  32'h44, 5'd0,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  5'd0,  5'd0,  0, 5'd0,  32'h0,        1, 0, 0, 3'd0));

    foreach (tbl[k]) begin
      v = tbl[k];
      drive(v);
      #1;
      chk($sformatf("row%0d rf_we", k), 64'(rf_we), 64'(v.ewe));
      if (v.ewe || v.rst) begin
        chk($sformatf("row%0d rf_waddr", k), 64'(rf_waddr), 64'(v.ea));
        chk($sformatf("row%0d rf_wdata", k), 64'(rf_wdata), 64'(v.ed));
      end
      chk($sformatf("row%0d lu_ready", k), 64'(lu_ready), 64'(v.erdy));
      chk($sformatf("row%0d qpend1", k), 64'(qpend1), 64'(v.ep1));
      chk($sformatf("row%0d qpend2", k), 64'(qpend2), 64'(v.ep2));
      chk($sformatf("row%0d q_count", k), 64'(q_count), 64'(v.ecnt));
      chk($sformatf("row%0d idle", k), 64'(idle), 64'(v.ecnt == 3'd0));
      tick();
    end

    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      pipe_we    = $urandom_range(0, 1) == 1;
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      lu_valid   = $urandom_range(0, 3) != 0;
      lu_waddr   = 5'($urandom_range(0, 7));
      lu_wdata   = $urandom;
      qaddr1     = 5'($urandom_range(0, 7));
      qaddr2     = 5'($urandom_range(0, 7));
      #1;
      model_check(c);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
